// File: rtl/carry_lookahead_adder4.sv
// carry_lookahead_adder4: registered 4-bit carry-lookahead adder with group propagate/generate.
module carry_lookahead_adder4 (
    input  logic       Clock,
    input  logic       ResetN,
    input  logic [3:0] InputA,
    input  logic [3:0] InputB,
    input  logic       InputCarry,
    output logic [3:0] Output,
    output logic       OutputCarry,
    output logic       OutputGroupPropagation,
    output logic       OutputGroupGeneration
);
    logic [3:0] g, p, s;
    logic [4:0] c;
    logic       grp_p, grp_g;
    // Every carry is a flat sum of products of g/p and the carry-in, so no carry depends on another.
    always_comb begin
        g     = InputA & InputB;
        p     = InputA ^ InputB;
        c[0]  = InputCarry;
        c[1]  = g[0] | (p[0] & InputCarry);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & InputCarry);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & InputCarry);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & InputCarry);
        s     = p ^ c[3:0];
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            Output                 <= 4'b0000;
            OutputCarry            <= 1'b0;
            OutputGroupPropagation <= 1'b0;
            OutputGroupGeneration  <= 1'b0;
        end else begin
            Output                 <= s;
            OutputCarry            <= c[4];
            OutputGroupPropagation <= grp_p;
            OutputGroupGeneration  <= grp_g;
        end
    end
endmodule

// File: tb/tb_carry_lookahead_adder4.sv
// tb_carry_lookahead_adder4: scoreboard bench; packed result is {carry, sum[3:0], P, G}.
module tb_carry_lookahead_adder4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       ci = 1'b0;
    logic [3:0] sum;
    logic       co, gp, gg;
    logic [6:0] sb[$];
    int         total = 0, passed = 0;

    carry_lookahead_adder4 dut (
        .Clock(clk), .ResetN(rst_n), .InputA(a), .InputB(b), .InputCarry(ci),
        .Output(sum), .OutputCarry(co),
        .OutputGroupPropagation(gp), .OutputGroupGeneration(gg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Independent reference: arithmetic sum, P from all-bits-differ, G as the carry of a+b alone.
    function automatic logic [6:0] model(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [4:0] full, bare;
        full = 5'(x) + 5'(y) + 5'(cin);
        bare = 5'(x) + 5'(y);
        return {full, &(x ^ y), bare[4]};
    endfunction

    // Inputs glitch before settling, so only the value present at the edge may matter.
    task automatic drive(input logic rn, input logic [3:0] x, input logic [3:0] y, input logic cin);
        @(negedge clk);
        a = ~x; b = ~y; ci = ~cin; rst_n = ~rn;
        #1;
        a = x; b = y; ci = cin; rst_n = rn;
        sb.push_back(rn ? model(x, y, cin) : 7'b0);
    endtask

    always @(posedge clk) begin
        logic [6:0] e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", {co, sum, gp, gg}, e);
            @(negedge clk);
            #2;
            check("hold", {co, sum, gp, gg}, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        drive(1'b0, 4'b1111, 4'b1111, 1'b1);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        drive(1'b1, 4'b0000, 4'b0000, 1'b0);
        drive(1'b1, 4'b0001, 4'b0000, 1'b0);
        drive(1'b1, 4'b0000, 4'b0000, 1'b1);
        drive(1'b1, 4'b1110, 4'b1111, 1'b1);
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        drive(1'b1, 4'b1010, 4'b0101, 1'b0);
        drive(1'b1, 4'b1010, 4'b0101, 1'b1);
        drive(1'b1, 4'b0111, 4'b0110, 1'b1);
        drive(1'b0, 4'b1001, 4'b1001, 1'b1);
        drive(1'b1, 4'b1001, 4'b1001, 1'b1);
        for (int i = 0; i < 512; i++)
            drive(1'b1, i[8:5], i[4:1], i[0]);
        repeat (3) @(posedge clk);
        #3;
        check("drain", 7'(sb.size()), 7'd0);
        check("final_sum", {co, sum, gp, gg}, model(4'b1111, 4'b1111, 1'b1));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/carry_lookahead_adder4.md
CARRY_LOOKAHEAD_ADDER4 -- requirements
Module: carry_lookahead_adder4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 ResetN  input  1  synchronous active-low reset, sampled only on Clock rising edge.
REQ-005 InputA  input  4  operand A, unsigned.
REQ-006 InputB  input  4  operand B, unsigned.
REQ-007 InputCarry  input  1  carry-in to bit 0.
REQ-008 Output  output  4  registered sum bits [3:0].
REQ-009 OutputCarry  output  1  registered carry-out of bit 3.
REQ-010 OutputGroupPropagation  output  1  registered group propagate P.
REQ-011 OutputGroupGeneration  output  1  registered group generate G.

Function
REQ-012 The block SHALL form per-bit generate g[i] = InputA[i] AND InputB[i] for i = 0..3.
REQ-013 The block SHALL form per-bit propagate p[i] = InputA[i] XOR InputB[i] for i = 0..3.
REQ-014 The block SHALL compute internal carries by lookahead, with no ripple chain:
- c0 = InputCarry
- c1 = g0 | p0c0
- c2 = g1 | p1g0 | p1p0c0
- c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
- c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
REQ-015 The block SHALL compute sum bit s[i] = p[i] XOR c[i].
REQ-016 The block SHALL compute group propagate P = p3 & p2 & p1 & p0.
REQ-017 The block SHALL compute group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0, independent of InputCarry.
REQ-018 The block SHALL satisfy c4 = G | (P & InputCarry) for every input combination.
REQ-019 The block SHALL guarantee that {OutputCarry, Output} equals InputA + InputB + InputCarry, modulo 32, with no overflow beyond 5 bits.
REQ-020 Inputs SHALL be sampled on the Clock rising edge; results SHALL appear on the outputs after that edge (latency 1 cycle, throughput 1 per cycle).
REQ-021 There SHALL be no handshake; a new operand set is accepted every cycle.
REQ-022 The outputs SHALL hold their values between edges and SHALL NOT change combinationally with the inputs.
REQ-023 P and G SHALL be mutually exclusive: P=1 implies G=0.
REQ-024 Inputs changing several times between edges SHALL have no effect; only the value present at the edge matters.

Reset
REQ-025 When ResetN=0 at a rising edge, Output SHALL be set to 4'b0000 and OutputCarry, OutputGroupPropagation and OutputGroupGeneration SHALL be set to 0.
REQ-026 Reset SHALL take priority over the computed result at the same edge.
REQ-027 Reset asserted mid-stream SHALL discard the sample at that edge.
REQ-028 The first edge with ResetN=1 SHALL register the current inputs normally.
REQ-029 Assertion or release of ResetN between edges SHALL have no effect.

Verification
REQ-030 Reset scenario: ResetN=0 with A=1111, B=1111, Cin=1 -> all outputs 0 after the edge; release -> Output=1111, OutputCarry=1, P=0, G=1.
REQ-031 Border scenarios:
- 0000+0000, Cin=0 -> Output=0000, OutputCarry=0, P=0, G=0
- 0001+0000, Cin=0 -> Output=0001, OutputCarry=0, P=0, G=0
- 0000+0000, Cin=1 -> Output=0001, OutputCarry=0, P=0, G=0
REQ-032 Saturation scenario: 1110+1111, Cin=1 -> Output=1110, OutputCarry=1, P=0, G=1; 1111+1111, Cin=0 -> Output=1110, OutputCarry=1, P=0, G=1.
REQ-033 Full-propagate scenario: 1010+0101, Cin=0 -> Output=1111, OutputCarry=0, P=1, G=0; same operands with Cin=1 -> Output=0000, OutputCarry=1, P=1, G=0.
REQ-034 Exhaustive scenario: all 512 combinations of (A, B, Cin) applied back-to-back -> each result equals the reference sum one cycle later and satisfies REQ-018.
